// File: rtl/fpu_noncomp_issue.sv
// Issue/writeback sequencer for the FPnew non-computational unit (SGNJ, MINMAX, CMP, CLASSIFY).
// One operation in flight, with sticky fflags, a response timeout and flush handling.
module fpu_noncomp_issue #(
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // request side
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_op_i,
    input  logic [2:0]            req_rnd_mode_i,
    input  logic                  req_op_mod_i,
    input  logic [63:0]           req_opa_i,
    input  logic [63:0]           req_opb_i,
    input  logic [TAG_W-1:0]      req_tag_i,
    // unit side
    output logic [1:0][31:0]      unit_operands_o,
    output logic [1:0]            unit_is_boxed_o,
    output logic [2:0]            unit_rnd_mode_o,
    output logic [3:0]            unit_op_o,
    output logic                  unit_op_mod_o,
    output logic [TAG_W-1:0]      unit_tag_o,
    output logic                  unit_in_valid_o,
    input  logic                  unit_in_ready_i,
    output logic                  unit_flush_o,
    output logic                  unit_out_ready_o,
    input  logic [31:0]           unit_result_i,
    input  logic [4:0]            unit_status_i,
    input  logic                  unit_ext_bit_i,
    input  logic [9:0]            unit_class_mask_i,
    input  logic                  unit_is_class_i,
    input  logic [TAG_W-1:0]      unit_tag_i,
    input  logic                  unit_out_valid_i,
    // writeback side
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [63:0]           wb_data_o,
    output logic                  wb_int_o,
    output logic [TAG_W-1:0]      wb_tag_o,
    // control / status
    input  logic                  flush_i,
    input  logic                  fflags_clr_i,
    output logic [4:0]            fflags_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    typedef enum logic [1:0] {OP_SGNJ, OP_MINMAX, OP_CMP, OP_CLASSIFY} req_op_e;

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    req_op_e            op_q, op_d;
    logic [2:0]         rnd_q, rnd_d;
    logic               mod_q, mod_d;
    logic [63:0]        opa_q, opa_d;
    logic [63:0]        opb_q, opb_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        data_q, data_d;
    logic               int_q, int_d;
    logic [4:0]         fflags_q, fflags_d;
    logic               err_q, err_d;

    logic               capture;
    logic               timeout;

    // A flush wins over a same-cycle response, so it also blocks the fflags update.
    assign capture = (state_q == WAIT) && unit_out_valid_i && (unit_tag_i == tag_q) && !flush_i;
    assign timeout = (state_q == WAIT) && !flush_i && !capture &&
                     (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rnd_d    = rnd_q;
        mod_d    = mod_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        tag_d    = tag_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        int_d    = int_q;
        err_d    = 1'b0;
        fflags_d = (fflags_clr_i ? 5'b0 : fflags_q) | (capture ? unit_status_i : 5'b0);

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    op_d    = req_op_e'(req_op_i);
                    rnd_d   = req_rnd_mode_i;
                    mod_d   = req_op_mod_i;
                    opa_d   = req_opa_i;
                    opb_d   = req_opb_i;
                    tag_d   = req_tag_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (unit_in_ready_i) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (capture) begin
                    data_d  = unit_is_class_i ? {54'b0, unit_class_mask_i}
                                              : {{32{unit_ext_bit_i}}, unit_result_i};
                    int_d   = (op_q == OP_CMP) || (op_q == OP_CLASSIFY) ||
                              ((op_q == OP_SGNJ) && mod_q);
                    state_d = RESP;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (flush_i || wb_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            op_q     <= OP_SGNJ;
            rnd_q    <= '0;
            mod_q    <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            tag_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            int_q    <= 1'b0;
            fflags_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rnd_q    <= rnd_d;
            mod_q    <= mod_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            int_q    <= int_d;
            fflags_q <= fflags_d;
            err_q    <= err_d;
        end
    end

    // Values follow fpnew_pkg::operation_e (SGNJ=6, MINMAX=7, CMP=8, CLASSIFY=9).
    always_comb begin
        unique case (op_q)
            OP_SGNJ:     unit_op_o = 4'd6;
            OP_MINMAX:   unit_op_o = 4'd7;
            OP_CMP:      unit_op_o = 4'd8;
            OP_CLASSIFY: unit_op_o = 4'd9;
            default:     unit_op_o = 4'd6;
        endcase
    end

    assign req_ready_o        = (state_q == IDLE) && rst_ni;
    assign unit_operands_o[0] = opa_q[31:0];
    assign unit_operands_o[1] = opb_q[31:0];
    assign unit_is_boxed_o[0] = &opa_q[63:32];
    assign unit_is_boxed_o[1] = &opb_q[63:32];
    assign unit_rnd_mode_o    = rnd_q;
    assign unit_op_mod_o      = mod_q;
    assign unit_tag_o         = tag_q;
    assign unit_in_valid_o    = (state_q == ISSUE);
    assign unit_out_ready_o   = (state_q == WAIT);
    assign unit_flush_o       = (flush_i && rst_ni) || err_q;
    assign wb_valid_o         = (state_q == RESP);
    assign wb_data_o          = data_q;
    assign wb_int_o           = int_q;
    assign wb_tag_o           = tag_q;
    assign fflags_o           = fflags_q;
    assign err_o              = err_q;

endmodule

// File: tb/tb_fpu_noncomp_issue.sv
// Directed bench for fpu_noncomp_issue: handshakes, writeback formatting, sticky flags,
// backpressure, timeout, flush, tag filtering and reset behaviour.
module tb_fpu_noncomp_issue;

    localparam int unsigned TAG_W = 5;
    localparam int unsigned TMO   = 15;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 req_valid, req_ready, req_mod;
    logic [1:0]           req_op;
    logic [2:0]           req_rnd;
    logic [63:0]          req_opa, req_opb;
    logic [TAG_W-1:0]     req_tag;
    logic [1:0][31:0]     u_operands;
    logic [1:0]           u_boxed;
    logic [2:0]           u_rnd;
    logic [3:0]           u_op;
    logic                 u_mod, u_in_valid, u_in_ready, u_flush, u_out_ready;
    logic [TAG_W-1:0]     u_tag_o, u_tag_i;
    logic [31:0]          u_result;
    logic [4:0]           u_status;
    logic                 u_ext, u_is_class, u_out_valid;
    logic [9:0]           u_class;
    logic                 wb_valid, wb_ready, wb_int;
    logic [63:0]          wb_data;
    logic [TAG_W-1:0]     wb_tag;
    logic                 flush, fclr, err;
    logic [4:0]           fflags;

    int n_cmp  = 0;
    int n_bad  = 0;
    int wb_cnt = 0;

    always #5 clk = ~clk;

    fpu_noncomp_issue #(.TAG_W(TAG_W), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_rnd_mode_i(req_rnd), .req_op_mod_i(req_mod), .req_opa_i(req_opa),
        .req_opb_i(req_opb), .req_tag_i(req_tag),
        .unit_operands_o(u_operands), .unit_is_boxed_o(u_boxed), .unit_rnd_mode_o(u_rnd),
        .unit_op_o(u_op), .unit_op_mod_o(u_mod), .unit_tag_o(u_tag_o),
        .unit_in_valid_o(u_in_valid), .unit_in_ready_i(u_in_ready), .unit_flush_o(u_flush),
        .unit_out_ready_o(u_out_ready), .unit_result_i(u_result), .unit_status_i(u_status),
        .unit_ext_bit_i(u_ext), .unit_class_mask_i(u_class), .unit_is_class_i(u_is_class),
        .unit_tag_i(u_tag_i), .unit_out_valid_i(u_out_valid),
        .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_data_o(wb_data),
        .wb_int_o(wb_int), .wb_tag_o(wb_tag),
        .flush_i(flush), .fflags_clr_i(fclr), .fflags_o(fflags), .err_o(err)
    );

    always @(posedge clk) if (rst_n && wb_valid && wb_ready) wb_cnt <= wb_cnt + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one request in IDLE; returns in the ISSUE cycle.
    task automatic send(input logic [1:0] op, input logic [2:0] rnd, input logic md,
                        input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] t);
        req_op = op; req_rnd = rnd; req_mod = md; req_opa = a; req_opb = b; req_tag = t;
        req_valid = 1'b1;
        #1;
        check_eq("req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
    endtask

    // Present one unit response for a single cycle.
    task automatic respond(input logic [TAG_W-1:0] t, input logic [31:0] res, input logic ext,
                           input logic [9:0] cls, input logic iscls, input logic [4:0] st);
        u_tag_i = t; u_result = res; u_ext = ext; u_class = cls; u_is_class = iscls;
        u_status = st; u_out_valid = 1'b1;
        tick();
        u_out_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waits;
        rst_n = 1'b0; req_valid = 0; req_op = 0; req_rnd = 0; req_mod = 0;
        req_opa = '0; req_opb = '0; req_tag = '0; u_in_ready = 1'b1; u_tag_i = '0;
        u_result = '0; u_status = '0; u_ext = 0; u_class = '0; u_is_class = 0;
        u_out_valid = 0; wb_ready = 1'b1; flush = 1'b1; fclr = 0;

        // reset values (flush_i held high to show unit_flush_o stays low in reset)
        repeat (2) tick();
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_in_valid", u_in_valid, 0);
        check_eq("rst_out_ready", u_out_ready, 0);
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_unit_flush", u_flush, 0);
        check_eq("rst_fflags", fflags, 0);
        check_eq("rst_wb_data", wb_data, 0);
        check_eq("rst_wb_tag", wb_tag, 0);
        flush = 1'b0;

        // FMV.X.W accepted in the first cycle after reset release
        rst_n = 1'b1;
        send(2'd0, 3'd3, 1'b1, 64'hFFFF_FFFF_BF80_0000, 64'h0000_0000_1234_5678, 5'h0A);
        check_eq("A_ready_issue", req_ready, 0);
        check_eq("A_in_valid", u_in_valid, 1);
        check_eq("A_opnd0", u_operands[0], 32'hBF80_0000);
        check_eq("A_opnd1", u_operands[1], 32'h1234_5678);
        check_eq("A_boxed", u_boxed, 2'b01);
        check_eq("A_op", u_op, 4'd6);
        check_eq("A_rnd", u_rnd, 3'd3);
        check_eq("A_mod", u_mod, 1);
        check_eq("A_utag", u_tag_o, 5'h0A);
        check_eq("A_out_ready_issue", u_out_ready, 0);
        tick();
        check_eq("A_out_ready_wait", u_out_ready, 1);
        check_eq("A_in_valid_wait", u_in_valid, 0);
        check_eq("A_wb_valid_c2", wb_valid, 0);
        respond(5'h0A, 32'hBF80_0000, 1'b1, 10'h0, 1'b0, 5'b0);
        check_eq("A_wb_valid_c3", wb_valid, 1);
        check_eq("A_wb_data", wb_data, 64'hFFFF_FFFF_BF80_0000);
        check_eq("A_wb_int", wb_int, 1);
        check_eq("A_wb_tag", wb_tag, 5'h0A);
        tick();
        check_eq("A_wb_done", wb_valid, 0);
        check_eq("A_wb_cnt", wb_cnt, 1);

        // unboxed operand, CLASSIFY
        send(2'd3, 3'd0, 1'b0, 64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'h03);
        check_eq("B_boxed", u_boxed, 2'b10);
        check_eq("B_op", u_op, 4'd9);
        tick();
        respond(5'h03, 32'hDEAD_BEEF, 1'b1, 10'h200, 1'b1, 5'b0);
        check_eq("B_wb_data", wb_data, 64'h200);
        check_eq("B_wb_int", wb_int, 1);
        check_eq("B_wb_tag", wb_tag, 5'h03);
        tick();
        check_eq("B_wb_cnt", wb_cnt, 2);

        // sticky flags
        send(2'd2, 3'd0, 1'b0, 64'hFFFF_FFFF_3F80_0000, 64'hFFFF_FFFF_3F80_0000, 5'h04);
        tick();
        respond(5'h04, 32'h1, 1'b0, 10'h0, 1'b0, 5'b10000);
        check_eq("C_cmp_data", wb_data, 64'h1);
        check_eq("C_cmp_int", wb_int, 1);
        check_eq("C_fflags_nv", fflags, 5'b10000);
        tick();
        send(2'd1, 3'd0, 1'b0, 64'hFFFF_FFFF_3F80_0000, 64'hFFFF_FFFF_4000_0000, 5'h05);
        tick();
        respond(5'h05, 32'h3F80_0000, 1'b0, 10'h0, 1'b0, 5'b0);
        check_eq("C_minmax_data", wb_data, 64'h3F80_0000);
        check_eq("C_minmax_int", wb_int, 0);
        check_eq("C_fflags_sticky", fflags, 5'b10000);
        tick();
        send(2'd2, 3'd0, 1'b0, 64'h0, 64'h0, 5'h06);
        tick();
        fclr = 1'b1;
        respond(5'h06, 32'h0, 1'b0, 10'h0, 1'b0, 5'b00001);
        fclr = 1'b0;
        check_eq("C_fflags_clr_cap", fflags, 5'b00001);
        tick();
        fclr = 1'b1;
        tick();
        fclr = 1'b0;
        check_eq("C_fflags_clr", fflags, 5'b0);
        check_eq("C_wb_cnt", wb_cnt, 5);

        // backpressure on both sides
        u_in_ready = 1'b0;
        send(2'd0, 3'd1, 1'b0, 64'hFFFF_FFFF_4000_0000, 64'hFFFF_FFFF_C000_0000, 5'h07);
        for (int i = 0; i < 4; i++) begin
            check_eq("D_in_valid", u_in_valid, 1);
            check_eq("D_opnd0", u_operands[0], 32'h4000_0000);
            check_eq("D_opnd1", u_operands[1], 32'hC000_0000);
            check_eq("D_boxed", u_boxed, 2'b11);
            check_eq("D_op", u_op, 4'd6);
            check_eq("D_rnd", u_rnd, 3'd1);
            check_eq("D_utag", u_tag_o, 5'h07);
            tick();
        end
        u_in_ready = 1'b1;
        check_eq("D_in_valid_last", u_in_valid, 1);
        tick();
        wb_ready = 1'b0;
        respond(5'h07, 32'hC000_0000, 1'b1, 10'h0, 1'b0, 5'b0);
        for (int i = 0; i < 3; i++) begin
            check_eq("D_wb_valid", wb_valid, 1);
            check_eq("D_wb_data", wb_data, 64'hFFFF_FFFF_C000_0000);
            check_eq("D_wb_int", wb_int, 0);
            check_eq("D_wb_tag", wb_tag, 5'h07);
            tick();
        end
        wb_ready = 1'b1;
        check_eq("D_wb_valid_hs", wb_valid, 1);
        tick();
        check_eq("D_wb_done", wb_valid, 0);
        check_eq("D_wb_cnt", wb_cnt, 6);

        // response timeout
        send(2'd1, 3'd0, 1'b0, 64'h0, 64'h0, 5'h08);
        tick();
        waits = 0;
        for (int i = 0; i < 40; i++) begin
            if (!(u_out_ready && !err)) break;
            waits++;
            tick();
        end
        check_eq("E_wait_cycles", waits, TMO);
        check_eq("E_err", err, 1);
        check_eq("E_unit_flush", u_flush, 1);
        check_eq("E_idle", req_ready, 1);
        check_eq("E_wb_valid", wb_valid, 0);
        tick();
        check_eq("E_err_pulse", err, 0);
        check_eq("E_flush_pulse", u_flush, 0);
        check_eq("E_wb_cnt", wb_cnt, 6);

        // flush in WAIT beats a same-cycle matching response
        send(2'd2, 3'd0, 1'b0, 64'h0, 64'h0, 5'h09);
        tick();
        flush = 1'b1;
        u_tag_i = 5'h09; u_status = 5'b00100; u_out_valid = 1'b1;
        #1;
        check_eq("F_unit_flush", u_flush, 1);
        tick();
        flush = 1'b0; u_out_valid = 1'b0;
        #1;
        check_eq("F_idle", req_ready, 1);
        check_eq("F_wb_valid", wb_valid, 0);
        check_eq("F_unit_flush_off", u_flush, 0);
        check_eq("F_fflags", fflags, 5'b0);
        check_eq("F_wb_cnt", wb_cnt, 6);

        // flush in IDLE is ignored; wrong tag ignored, correct tag written back
        flush = 1'b1;
        send(2'd2, 3'd0, 1'b0, 64'h0, 64'h0, 5'h0A);
        flush = 1'b0;
        check_eq("G_in_valid", u_in_valid, 1);
        tick();
        respond(5'h0B, 32'h1, 1'b0, 10'h0, 1'b0, 5'b00100);
        check_eq("G_still_wait", u_out_ready, 1);
        check_eq("G_no_wb", wb_valid, 0);
        check_eq("G_fflags_ign", fflags, 5'b0);
        respond(5'h0A, 32'h1, 1'b0, 10'h0, 1'b0, 5'b00010);
        check_eq("G_wb_valid", wb_valid, 1);
        check_eq("G_wb_data", wb_data, 64'h1);
        check_eq("G_wb_tag", wb_tag, 5'h0A);
        check_eq("G_fflags", fflags, 5'b00010);
        tick();
        check_eq("G_wb_cnt", wb_cnt, 7);

        // reset mid-operation
        send(2'd0, 3'd0, 1'b0, 64'hFFFF_FFFF_BF80_0000, 64'h0, 5'h0C);
        tick();
        check_eq("H_wait", u_out_ready, 1);
        rst_n = 1'b0;
        #1;
        check_eq("H_out_ready", u_out_ready, 0);
        check_eq("H_req_ready", req_ready, 0);
        check_eq("H_fflags", fflags, 5'b0);
        check_eq("H_wb_tag", wb_tag, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("H_idle", req_ready, 1);
        check_eq("H_wb_valid", wb_valid, 0);
        check_eq("H_wb_cnt", wb_cnt, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fpu_noncomp_issue.md
FPU_NONCOMP_ISSUE -- requirements
Module: fpu_noncomp_issue

Interface
REQ-001 SHALL have parameter TAG_W, default 5, destination register tag width.
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum WAIT cycles before the error abort.
REQ-003 SHALL have ports clk_i, input, 1, single clock; rst_ni, input, 1, reset, asynchronous active-low.
REQ-004 SHALL have request ports: req_valid_i in 1; req_ready_o out 1; req_op_i in 2 (0 SGNJ, 1 MINMAX, 2 CMP, 3 CLASSIFY); req_rnd_mode_i in 3; req_op_mod_i in 1; req_opa_i in 64; req_opb_i in 64; req_tag_i in TAG_W.
REQ-005 SHALL have unit-side outputs: unit_operands_o 2x32; unit_is_boxed_o 2; unit_rnd_mode_o 3; unit_op_o (fpnew_pkg operation_e); unit_op_mod_o 1; unit_tag_o TAG_W; unit_in_valid_o 1; unit_flush_o 1; unit_out_ready_o 1.
REQ-006 SHALL have unit-side inputs: unit_in_ready_i 1; unit_result_i 32; unit_status_i 5 (NV,DZ,OF,UF,NX); unit_ext_bit_i 1; unit_class_mask_i 10; unit_is_class_i 1; unit_tag_i TAG_W; unit_out_valid_i 1.
REQ-007 SHALL have writeback ports: wb_valid_o out 1; wb_ready_i in 1; wb_data_o out 64; wb_int_o out 1 (1 = integer regfile); wb_tag_o out TAG_W.
REQ-008 SHALL have ports flush_i in 1; fflags_clr_i in 1; fflags_o out 5 (sticky); err_o out 1 (one-cycle timeout pulse).

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, allowing one operation in flight.
REQ-010 SHALL assert req_ready_o only in IDLE; req_valid_i and req_ready_o both high SHALL capture all request fields and move to ISSUE.
REQ-011 SHALL drive unit_operands_o[i] from the low 32 bits of the captured operand i.
REQ-012 SHALL drive unit_is_boxed_o[i] = 1 exactly when bits 63:32 of operand i are all ones.
REQ-013 SHALL assert unit_in_valid_o only in ISSUE, with all unit_* request fields stable, and move to WAIT in the cycle where unit_in_ready_i=1.
REQ-014 SHALL hold unit_out_ready_o=1 in WAIT and 0 elsewhere.
REQ-015 In WAIT, unit_out_valid_i=1 with unit_tag_i equal to the issued tag SHALL capture the result and move to RESP.
REQ-016 In WAIT, unit_out_valid_i=1 with a mismatched tag SHALL be ignored, staying in WAIT.
REQ-017 On capture, wb_data_o SHALL be {54'b0, class_mask} if unit_is_class_i=1, else {32{unit_ext_bit_i}, unit_result_i}.
REQ-018 wb_int_o SHALL be 1 when op is CMP or CLASSIFY, or op is SGNJ with op_mod=1; 0 otherwise.
REQ-019 wb_tag_o SHALL equal the issued tag.
REQ-020 SHALL assert wb_valid_o only in RESP, holding wb_data_o, wb_int_o and wb_tag_o stable until wb_ready_i=1, then return to IDLE.
REQ-021 Best-case latency from the accept cycle to wb_valid_o SHALL be 3 cycles (ISSUE, WAIT, RESP), given unit ready and unit 1-cycle latency.
REQ-022 On capture, fflags_o SHALL OR in unit_status_i.
REQ-023 fflags_clr_i SHALL zero fflags_o; if clear and capture occur in the same cycle, the result SHALL be unit_status_i only.
REQ-024 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-025 When the wait counter reaches TIMEOUT without a capture, the block SHALL pulse err_o, drive unit_flush_o for 1 cycle, and return to IDLE with no writeback.
REQ-026 flush_i in ISSUE, WAIT or RESP SHALL abandon the operation and return to IDLE next cycle, with no wb_valid_o and no fflags update; unit_flush_o SHALL mirror flush_i.
REQ-027 flush_i in IDLE SHALL have no effect; flush_i takes priority over a same-cycle capture or wb handshake.

Reset
REQ-028 rst_ni low SHALL immediately force IDLE.
REQ-029 During reset, req_ready_o, unit_in_valid_o, unit_out_ready_o, wb_valid_o, err_o and unit_flush_o SHALL be 0; fflags_o, the counter, and the captured data/tag SHALL be 0.
REQ-030 Reset mid-operation SHALL drop the operation silently.
REQ-031 The first request SHALL be accepted in the first cycle after rst_ni rises.

Verification
REQ-032 FMV.X.W case: op SGNJ, rnd RUP, op_mod 1, opa=0xFFFFFFFF_BF800000, unit returns ext 1 -> wb_data 0xFFFFFFFF_BF800000, wb_int 1, wb_valid in cycle 3.
REQ-033 Unboxed operand case: opa=0x00000000_3F800000 -> unit_is_boxed_o[0]=0; CLASSIFY with mask 0x200 -> wb_data 0x200, wb_int 1.
REQ-034 Sticky flags case: CMP with unit status NV, then MINMAX with status 0 -> fflags_o=5'b10000 after both; fflags_clr_i plus a capture with NX in the same cycle -> 5'b00001.
REQ-035 Backpressure case: unit_in_ready_i low for 4 cycles, then wb_ready_i low for 3 cycles -> unit request and wb fields stable throughout, one writeback only.
REQ-036 Timeout case: no unit_out_valid_i for TIMEOUT cycles -> err_o pulse, unit_flush_o pulse, IDLE, no wb.
REQ-037 Flush and tag case: flush_i in WAIT -> IDLE, no wb; a mismatched-tag response -> ignored, and a later correct-tag response -> written back.
